level_manager: RTL and testbench
================================

// Module: level_manager
// PURPOSE
//  Consumes the per-pixel collision levels and bird-state pulses produced by the game controller.
//  Tracks pigs and birds remaining, score and current level, and requests level loads from the loader.
//  Drives pigs_left, current_level and game_over back into the game controller.
//  Sits between the game controller, the level loader and the score/HUD display.
// PARAMETERS
//  NUM_LEVELS       3    number of levels; valid levels are 0..NUM_LEVELS-1
//  MAX_PIGS         7    pig-count ceiling; larger loader values are clamped to this
//  BIRDS_PER_LEVEL  3    birds granted at each level load
//  SCORE_W          16   score width in bits
//  PIG_POINTS       100  points added per pig kill
//  WOOD_POINTS      10   points added per wood-hit frame
//  SETTLE_FRAMES    30   frames to wait after the last bird rests before declaring game over
// PORTS
//  clk               in   1        system clock
//  reset             in   1        synchronous, active-high reset
//  startOfFrame      in   1        one-cycle pulse at the start of each frame
//  collision_bird_pig in  1        level signal; high on each pixel where bird and pig overlap
//  collision_bird_wood in 1        level signal; high on each pixel where bird and wood overlap
//  bird_at_rest      in   1        one-cycle pulse when the launched bird stops or leaves the screen
//  restart           in   1        one-cycle pulse; in GAME_OVER or WIN, restarts at level 0
//  load_req          out  1        request to load current_level
//  load_ack          in   1        one-cycle pulse from the loader; load_pig_count is valid in that cycle
//  load_pig_count    in   4        number of pigs in the loaded level
//  pigs_left         out  1        1 when pigs_remaining != 0
//  pigs_remaining    out  4        live pig count
//  birds_left        out  2        birds not yet used in this level
//  current_level     out  4        active level index
//  score             out  SCORE_W  accumulated score
//  level_done        out  1        one-cycle pulse when a level is cleared
//  game_over         out  1        sticky; all birds used with pigs still alive
//  game_won          out  1        sticky; last level cleared
// BEHAVIOUR
//  Reset values:
//   - state=LOAD; all counters and score are 0.
//   - load_req=1 (the first load request goes out immediately after reset).
//   - level_done, game_over and game_won are 0.
//  Per-frame event detection:
//   - pig_seen and wood_seen flags clear on startOfFrame.
//   - The first cycle a collision input is high while its flag is 0 sets the flag and produces an internal event.
//   - At most one pig event and one wood event per frame.
//   - Counters and score update on the next clk edge (1-cycle latency from the first overlapping pixel).
//   - If startOfFrame and a collision input are high in the same cycle, the flag clears and the event counts.
//  State LOAD:
//   - load_req is held at 1 until load_ack.
//   - On load_ack: pigs_remaining=min(load_pig_count,MAX_PIGS); birds_left=BIRDS_PER_LEVEL; load_req drops; go to PLAY.
//   - Collision events are ignored in LOAD.
//  State PLAY:
//   - pig event: pigs_remaining-- and score+=PIG_POINTS.
//   - wood event: score+=WOOD_POINTS.
//   - Score saturates at all-ones and never wraps.
//   - If pigs_remaining reaches 0 (or was loaded as 0): go to DONE.
//   - bird_at_rest: birds_left-- (floor 0). If the new value is 0 and pigs_remaining>0, go to SETTLE.
//   - Pig event and bird_at_rest in the same cycle: the pig event is applied first. If it kills the last pig, go to DONE; the bird decrement still applies.
//  State SETTLE:
//   - Counts startOfFrame pulses up to SETTLE_FRAMES; pig and wood events still score.
//   - If pigs_remaining reaches 0: go to DONE.
//   - If the count reaches SETTLE_FRAMES: game_over=1; go to GAME_OVER.
//  State DONE (1 cycle):
//   - level_done=1.
//   - If current_level==NUM_LEVELS-1: game_won=1; go to WIN.
//   - Otherwise: current_level++, load_req=1, go to LOAD.
//  States GAME_OVER / WIN:
//   - Terminal; outputs are frozen and all inputs are ignored except restart.
//   - restart: current_level=0, score=0, game_over=0, game_won=0, load_req=1, go to LOAD.
//  Reset is synchronous and overrides every other input in the same cycle, including a pending load_ack.
//  load_ack outside LOAD is ignored.
//  All outputs are registered; no output is combinational from an input.
// TESTING
//  1. Reset, then load_ack with count=2 -> PLAY, pigs_remaining=2, birds_left=3, load_req=0, score=0.
//  2. Pig collision held 40 pixels in one frame -> pigs_remaining 2->1, score=100.
//     Next frame, pig collision again -> pigs_remaining=0, level_done pulse, current_level=1, load_req=1.
//  3. Three bird_at_rest pulses with 1 pig alive, then 30 frames -> game_over=1 on the 30th frame.
//     Repeat, but inject a pig hit at frame 10 -> level_done instead of game_over.
//  4. Pig event and final bird_at_rest in the same cycle with 1 pig left -> DONE, game_over stays 0.
//  5. Clear level 2 (NUM_LEVELS=3) -> game_won=1, load_req=0.
//     Then restart -> level 0, score 0, load_req=1.
//  6. load_pig_count=12 -> pigs_remaining=7.
//     Separately: score preset near max, then wood hit -> score=16'hFFFF.
//     Separately: reset asserted mid-SETTLE -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/level_manager.sv
// Level/score bookkeeping for the bird game: counts pigs, birds and score,
// sequences level loads and reports level completion, game over and win.
module level_manager #(
  parameter int NUM_LEVELS      = 3,
  parameter int MAX_PIGS        = 7,
  parameter int BIRDS_PER_LEVEL = 3,
  parameter int SCORE_W         = 16,
  parameter int PIG_POINTS      = 100,
  parameter int WOOD_POINTS     = 10,
  parameter int SETTLE_FRAMES   = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               collision_bird_pig,
  input  logic               collision_bird_wood,
  input  logic               bird_at_rest,
  input  logic               restart,
  output logic               load_req,
  input  logic               load_ack,
  input  logic [3:0]         load_pig_count,
  output logic               pigs_left,
  output logic [3:0]         pigs_remaining,
  output logic [1:0]         birds_left,
  output logic [3:0]         current_level,
  output logic [SCORE_W-1:0] score,
  output logic               level_done,
  output logic               game_over,
  output logic               game_won
);

  localparam int SETTLE_W = $clog2(SETTLE_FRAMES + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_PLAY,
    S_SETTLE,
    S_DONE,
    S_GAME_OVER,
    S_WIN
  } state_t;

  state_t              state, state_nxt;
  logic                pig_seen, pig_seen_nxt;
  logic                wood_seen, wood_seen_nxt;
  logic [SETTLE_W-1:0] settle_cnt, settle_cnt_nxt;
  logic                load_req_nxt;
  logic [3:0]          pigs_nxt;
  logic [1:0]          birds_nxt;
  logic [3:0]          level_nxt;
  logic [SCORE_W-1:0]  score_nxt;
  logic                level_done_nxt;
  logic                game_over_nxt;
  logic                game_won_nxt;

  logic                pig_evt, wood_evt, pig_kill;
  logic [SCORE_W:0]    add_pts;
  logic [SCORE_W:0]    score_sum;
  logic [SCORE_W-1:0]  score_sat;
  logic [3:0]          pigs_dec;

  // A flag cleared by startOfFrame in the same cycle still lets that pixel count.
  always_comb begin
    pig_evt       = collision_bird_pig  & (startOfFrame | ~pig_seen);
    wood_evt      = collision_bird_wood & (startOfFrame | ~wood_seen);
    pig_seen_nxt  = collision_bird_pig  | (pig_seen  & ~startOfFrame);
    wood_seen_nxt = collision_bird_wood | (wood_seen & ~startOfFrame);

    pig_kill = pig_evt & (pigs_remaining != 4'd0);
    pigs_dec = pig_kill ? pigs_remaining - 4'd1 : pigs_remaining;

    add_pts = '0;
    if (pig_kill) add_pts = add_pts + (SCORE_W+1)'(PIG_POINTS);
    if (wood_evt) add_pts = add_pts + (SCORE_W+1)'(WOOD_POINTS);
    score_sum = {1'b0, score} + add_pts;
    score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  always_comb begin
    state_nxt      = state;
    settle_cnt_nxt = settle_cnt;
    load_req_nxt   = load_req;
    pigs_nxt       = pigs_remaining;
    birds_nxt      = birds_left;
    level_nxt      = current_level;
    score_nxt      = score;
    level_done_nxt = 1'b0;
    game_over_nxt  = game_over;
    game_won_nxt   = game_won;

    case (state)
      S_LOAD: begin
        if (load_ack) begin
          pigs_nxt     = (load_pig_count > 4'(MAX_PIGS)) ? 4'(MAX_PIGS) : load_pig_count;
          birds_nxt    = 2'(BIRDS_PER_LEVEL);
          load_req_nxt = 1'b0;
          state_nxt    = S_PLAY;
        end
      end
      S_PLAY: begin
        pigs_nxt  = pigs_dec;
        score_nxt = score_sat;
        if (bird_at_rest && birds_left != 2'd0) birds_nxt = birds_left - 2'd1;
        // A last-pig kill wins over running out of birds in the same cycle.
        if (pigs_dec == 4'd0) begin
          state_nxt      = S_DONE;
          level_done_nxt = 1'b1;
        end else if (bird_at_rest && birds_nxt == 2'd0) begin
          state_nxt      = S_SETTLE;
          settle_cnt_nxt = '0;
        end
      end
      S_SETTLE: begin
        pigs_nxt  = pigs_dec;
        score_nxt = score_sat;
        if (startOfFrame) settle_cnt_nxt = settle_cnt + SETTLE_W'(1);
        if (pigs_dec == 4'd0) begin
          state_nxt      = S_DONE;
          level_done_nxt = 1'b1;
        end else if (startOfFrame && settle_cnt == SETTLE_W'(SETTLE_FRAMES - 1)) begin
          game_over_nxt = 1'b1;
          state_nxt     = S_GAME_OVER;
        end
      end
      S_DONE: begin
        if (current_level == 4'(NUM_LEVELS - 1)) begin
          game_won_nxt = 1'b1;
          state_nxt    = S_WIN;
        end else begin
          level_nxt    = current_level + 4'd1;
          load_req_nxt = 1'b1;
          state_nxt    = S_LOAD;
        end
      end
      S_GAME_OVER, S_WIN: begin
        if (restart) begin
          level_nxt     = 4'd0;
          score_nxt     = '0;
          game_over_nxt = 1'b0;
          game_won_nxt  = 1'b0;
          load_req_nxt  = 1'b1;
          state_nxt     = S_LOAD;
        end
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_LOAD;
      pig_seen       <= 1'b0;
      wood_seen      <= 1'b0;
      settle_cnt     <= '0;
      load_req       <= 1'b1;
      pigs_remaining <= 4'd0;
      pigs_left      <= 1'b0;
      birds_left     <= 2'd0;
      current_level  <= 4'd0;
      score          <= '0;
      level_done     <= 1'b0;
      game_over      <= 1'b0;
      game_won       <= 1'b0;
    end else begin
      state          <= state_nxt;
      pig_seen       <= pig_seen_nxt;
      wood_seen      <= wood_seen_nxt;
      settle_cnt     <= settle_cnt_nxt;
      load_req       <= load_req_nxt;
      pigs_remaining <= pigs_nxt;
      pigs_left      <= (pigs_nxt != 4'd0);
      birds_left     <= birds_nxt;
      current_level  <= level_nxt;
      score          <= score_nxt;
      level_done     <= level_done_nxt;
      game_over      <= game_over_nxt;
      game_won       <= game_won_nxt;
    end
  end

endmodule

// File: tb/tb_level_manager.sv
// Directed game scenarios followed by random play, every cycle compared
// against a phase-level reference model of the game rules.
module tb_level_manager;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, collision_bird_pig, collision_bird_wood;
  logic        bird_at_rest, restart, load_ack;
  logic [3:0]  load_pig_count;
  logic        load_req, pigs_left, level_done, game_over, game_won;
  logic [3:0]  pigs_remaining, current_level;
  logic [1:0]  birds_left;
  logic [15:0] score;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  level_manager dut (
    .clk                (clk),
    .reset              (reset),
    .startOfFrame       (startOfFrame),
    .collision_bird_pig (collision_bird_pig),
    .collision_bird_wood(collision_bird_wood),
    .bird_at_rest       (bird_at_rest),
    .restart            (restart),
    .load_req           (load_req),
    .load_ack           (load_ack),
    .load_pig_count     (load_pig_count),
    .pigs_left          (pigs_left),
    .pigs_remaining     (pigs_remaining),
    .birds_left         (birds_left),
    .current_level      (current_level),
    .score              (score),
    .level_done         (level_done),
    .game_over          (game_over),
    .game_won           (game_won)
  );

  // Reference model: game phase plus plain integer bookkeeping.
  localparam int P_LOAD = 0, P_PLAY = 1, P_SETTLE = 2, P_DONE = 3, P_OVER = 4, P_WIN = 5;
  int m_phase, m_pigs, m_birds, m_level, m_score, m_frames;
  bit m_pig_flag, m_wood_flag, m_req, m_done, m_over, m_won;

  task automatic model_reset();
    m_phase = P_LOAD; m_pigs = 0; m_birds = 0; m_level = 0; m_score = 0; m_frames = 0;
    m_pig_flag = 0; m_wood_flag = 0; m_req = 1; m_done = 0; m_over = 0; m_won = 0;
  endtask

  task automatic model_step();
    bit pig_hit, wood_hit;
    int kills;
    if (reset) begin
      model_reset();
      return;
    end
    pig_hit  = collision_bird_pig  && (startOfFrame || !m_pig_flag);
    wood_hit = collision_bird_wood && (startOfFrame || !m_wood_flag);
    m_pig_flag  = collision_bird_pig  || (m_pig_flag  && !startOfFrame);
    m_wood_flag = collision_bird_wood || (m_wood_flag && !startOfFrame);
    m_done = 0;
    case (m_phase)
      P_LOAD: if (load_ack) begin
        m_pigs  = (load_pig_count > 7) ? 7 : int'(load_pig_count);
        m_birds = 3;
        m_req   = 0;
        m_phase = P_PLAY;
      end
      P_PLAY, P_SETTLE: begin
        kills   = (pig_hit && m_pigs > 0) ? 1 : 0;
        m_pigs  = m_pigs - kills;
        m_score = m_score + 100 * kills + (wood_hit ? 10 : 0);
        if (m_score > 65535) m_score = 65535;
        if (m_phase == P_PLAY) begin
          if (bird_at_rest && m_birds > 0) m_birds--;
          if (m_pigs == 0) begin m_phase = P_DONE; m_done = 1; end
          else if (bird_at_rest && m_birds == 0) begin m_phase = P_SETTLE; m_frames = 0; end
        end else begin
          if (startOfFrame) m_frames++;
          if (m_pigs == 0) begin m_phase = P_DONE; m_done = 1; end
          else if (m_frames >= 30) begin m_over = 1; m_phase = P_OVER; end
        end
      end
      P_DONE: begin
        if (m_level == 2) begin m_won = 1; m_phase = P_WIN; end
        else begin m_level++; m_req = 1; m_phase = P_LOAD; end
      end
      default: if (restart) begin
        m_level = 0; m_score = 0; m_over = 0; m_won = 0; m_req = 1; m_phase = P_LOAD;
      end
    endcase
  endtask

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_output();
    check_val("load_req",       32'(load_req),       32'(m_req));
    check_val("pigs_remaining", 32'(pigs_remaining), 32'(m_pigs));
    check_val("pigs_left",      32'(pigs_left),      32'(m_pigs != 0));
    check_val("birds_left",     32'(birds_left),     32'(m_birds));
    check_val("current_level",  32'(current_level),  32'(m_level));
    check_val("score",          32'(score),          32'(m_score));
    check_val("level_done",     32'(level_done),     32'(m_done));
    check_val("game_over",      32'(game_over),      32'(m_over));
    check_val("game_won",       32'(game_won),       32'(m_won));
  endtask

  // Drive one cycle of inputs, clock it, advance the model, then compare.
  task automatic apply_stimulus(input bit sof, input bit cp, input bit cw, input bit bar,
                                input bit ack, input logic [3:0] cnt, input bit rs, input bit rst);
    startOfFrame = sof; collision_bird_pig = cp; collision_bird_wood = cw;
    bird_at_rest = bar; load_ack = ack; load_pig_count = cnt; restart = rs; reset = rst;
    @(posedge clk);
    model_step();
    #1;
    check_output();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 4'd0, 0, 0);
  endtask

  task automatic frame_tick();
    apply_stimulus(1, 0, 0, 0, 0, 4'd0, 0, 0);
    idle(2);
  endtask

  task automatic load_level(input logic [3:0] cnt);
    apply_stimulus(0, 0, 0, 0, 1, cnt, 0, 0);
  endtask

  task automatic three_birds();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 0, 1, 0, 4'd0, 0, 0);
      idle(1);
    end
  endtask

  initial begin
    model_reset();
    apply_stimulus(0, 0, 0, 0, 0, 4'd0, 0, 1);
    apply_stimulus(0, 0, 0, 0, 1, 4'd5, 0, 1);
    check_val("reset_load_req", 32'(load_req), 32'd1);
    check_val("reset_score", 32'(score), 32'd0);
    check_val("reset_game_over", 32'(game_over), 32'd0);
    idle(2);

    // Load two pigs, then one long collision and one short collision in separate frames.
    load_level(4'd2);
    check_val("t1_pigs", 32'(pigs_remaining), 32'd2);
    check_val("t1_birds", 32'(birds_left), 32'd3);
    check_val("t1_load_req", 32'(load_req), 32'd0);
    frame_tick();
    for (int i = 0; i < 40; i++) apply_stimulus(0, 1, 0, 0, 0, 4'd0, 0, 0);
    check_val("t2_pigs_after_40px", 32'(pigs_remaining), 32'd1);
    check_val("t2_score_after_40px", 32'(score), 32'd100);
    apply_stimulus(1, 0, 0, 0, 0, 4'd0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 4'd0, 0, 0);
    check_val("t2_level_done", 32'(level_done), 32'd1);
    apply_stimulus(0, 1, 0, 0, 0, 4'd0, 0, 0);
    check_val("t2_next_level", 32'(current_level), 32'd1);
    check_val("t2_load_req", 32'(load_req), 32'd1);

    // Level 1: run out of birds and let the settle window expire.
    load_level(4'd1);
    three_birds();
    for (int f = 1; f <= 30; f++) begin
      frame_tick();
      if (f == 29) check_val("t3_not_over_f29", 32'(game_over), 32'd0);
    end
    check_val("t3_game_over", 32'(game_over), 32'd1);
    idle(3);
    apply_stimulus(0, 0, 0, 0, 0, 4'd0, 1, 0);
    check_val("t3_restart_level", 32'(current_level), 32'd0);

    // Same again, but a pig is hit during frame 10 of the settle window.
    load_level(4'd1);
    three_birds();
    for (int f = 1; f <= 9; f++) frame_tick();
    apply_stimulus(1, 0, 0, 0, 0, 4'd0, 0, 0);
    apply_stimulus(0, 1, 0, 0, 0, 4'd0, 0, 0);
    check_val("t3_settle_kill_done", 32'(level_done), 32'd1);
    check_val("t3_settle_kill_no_over", 32'(game_over), 32'd0);
    idle(2);

    // Level 1: last pig and last bird in the same cycle.
    load_level(4'd1);
    for (int i = 0; i < 2; i++) begin apply_stimulus(0, 0, 0, 1, 0, 4'd0, 0, 0); idle(1); end
    apply_stimulus(1, 1, 0, 1, 0, 4'd0, 0, 0);
    check_val("t4_done", 32'(level_done), 32'd1);
    check_val("t4_birds", 32'(birds_left), 32'd0);
    idle(2);
    check_val("t4_no_over", 32'(game_over), 32'd0);

    // Level 2 is the last one: clearing it wins, restart goes back to level 0.
    load_level(4'd1);
    apply_stimulus(1, 1, 1, 0, 0, 4'd0, 0, 0);
    idle(2);
    check_val("t5_won", 32'(game_won), 32'd1);
    check_val("t5_load_req", 32'(load_req), 32'd0);
    apply_stimulus(1, 1, 1, 1, 1, 4'd3, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 4'd0, 1, 0);
    check_val("t5_restart_level", 32'(current_level), 32'd0);
    check_val("t5_restart_score", 32'(score), 32'd0);
    check_val("t5_restart_req", 32'(load_req), 32'd1);

    // Oversized pig count clamps, then wood hits drive the score into saturation.
    load_level(4'd12);
    check_val("t6_clamp", 32'(pigs_remaining), 32'd7);
    for (int i = 0; i < 6553; i++) apply_stimulus(1, 0, 1, 0, 0, 4'd0, 0, 0);
    check_val("t6_score_near_max", 32'(score), 32'd65530);
    apply_stimulus(1, 0, 1, 0, 0, 4'd0, 0, 0);
    check_val("t6_score_sat", 32'(score), 32'hFFFF);
    apply_stimulus(1, 0, 1, 0, 0, 4'd0, 0, 0);
    check_val("t6_score_hold", 32'(score), 32'hFFFF);

    // Reset in the middle of a settle window, together with a stray load_ack.
    three_birds();
    for (int f = 0; f < 5; f++) frame_tick();
    apply_stimulus(1, 1, 1, 1, 1, 4'd4, 1, 1);
    check_val("t6_reset_req", 32'(load_req), 32'd1);
    check_val("t6_reset_pigs", 32'(pigs_remaining), 32'd0);
    check_val("t6_reset_score", 32'(score), 32'd0);

    // Random play.
    for (int i = 0; i < 4000; i++) begin
      apply_stimulus(($urandom % 8) == 0, ($urandom % 12) == 0, ($urandom % 6) == 0,
                     ($urandom % 24) == 0, ($urandom % 4) == 0, 4'($urandom_range(0, 15)),
                     ($urandom % 10) == 0, ($urandom % 700) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
